// File: rtl/lemming_world.sv
// -----------------------------------------------------------------------------
// lemming_world
//
// 1-D terrain model for closed-loop exercise of the lemming walker FSM. It
// watches the walker's state outputs and the shared dig command, tracks the
// lemming's cell, dug-out ground and fall progress, and feeds back the
// environment inputs (ground and both bump sensors) the walker needs.
//
// Optional feature macro: LEMMING_WORLD_STATS_EN
//   defined     -> saturating step_count / fall_count statistics counters
//   not defined -> step_count and fall_count are constant 0, no counter flops
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   resetn      in   synchronous active-low reset
//   load        in   load terrain/wall maps, return lemming to START_POS
//   terrain_in  in   [WIDTH] bit i = solid ground under cell i
//   wall_in     in   [WIDTH] bit i = cell i is an impassable wall
//   dig         in   dig command shared with the walker (blocks stepping)
//   walk_left   in   walker state output
//   walk_right  in   walker state output
//   aaah        in   walker state output (falling)
//   digging     in   walker state output
//   bump_left   out  wall or track edge immediately left of the lemming
//   bump_right  out  wall or track edge immediately right of the lemming
//   ground      out  solid ground under the lemming's current cell
//   pos         out  [PW] current lemming cell
//   landed      out  one-cycle pulse on the cycle a fall ends
//   step_count  out  [16] saturating count of steps taken
//   fall_count  out  [8]  saturating count of landings
// -----------------------------------------------------------------------------
module lemming_world #(
  parameter int WIDTH      = 16,
  parameter int START_POS  = 0,
  parameter int DIG_CYCLES = 4,
  parameter int FALL_DEPTH = 3,
  localparam int PW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] terrain_in,
  input  logic [WIDTH-1:0] wall_in,
  input  logic             dig,
  input  logic             walk_left,
  input  logic             walk_right,
  input  logic             aaah,
  input  logic             digging,
  output logic             bump_left,
  output logic             bump_right,
  output logic             ground,
  output logic [PW-1:0]    pos,
  output logic             landed,
  output logic [15:0]      step_count,
  output logic [7:0]       fall_count
);

  // Counter widths stay at least one bit so DIG_CYCLES/FALL_DEPTH of 1 work.
  localparam int DW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;
  localparam int FW = (FALL_DEPTH > 1) ? $clog2(FALL_DEPTH) : 1;

  localparam logic [PW-1:0]    START_P   = PW'(START_POS);
  localparam logic [PW-1:0]    LAST_P    = PW'(WIDTH - 1);
  localparam logic [DW-1:0]    DIG_LAST  = DW'(DIG_CYCLES - 1);
  localparam logic [FW-1:0]    FALL_LAST = FW'(FALL_DEPTH - 1);
  localparam logic [WIDTH-1:0] START_MASK = {{(WIDTH-1){1'b0}}, 1'b1} << START_POS;

  logic [WIDTH-1:0] t_map;
  logic [WIDTH-1:0] w_map;
  logic [DW-1:0]    dig_cnt;
  logic [FW-1:0]    fall_cnt;

  logic [PW-1:0] pos_dec;
  logic [PW-1:0] pos_inc;
  logic          step_l;
  logic          step_r;
  logic          dig_done;
  logic          fall_done;

  // Combinational decode of the registered position and maps
  assign pos_dec = pos - PW'(1);
  assign pos_inc = pos + PW'(1);

  // The edge term short-circuits, so the neighbour index is never used
  // out of range (it would wrap at the track ends).
  assign ground     = t_map[pos];
  assign bump_left  = (pos == '0)     ? 1'b1 : w_map[pos_dec];
  assign bump_right = (pos == LAST_P) ? 1'b1 : w_map[pos_inc];

  // Both walk outputs high is illegal and produces no step; dig freezes steps.
  assign step_l = walk_left  & ~walk_right & ground & ~bump_left  & ~dig;
  assign step_r = walk_right & ~walk_left  & ground & ~bump_right & ~dig;

  assign dig_done  = (dig_cnt  == DIG_LAST);
  assign fall_done = (fall_cnt == FALL_LAST);

  // World state update
  always_ff @(posedge clk) begin
    if (!resetn) begin
      t_map    <= '1;
      w_map    <= '0;
      pos      <= START_P;
      dig_cnt  <= '0;
      fall_cnt <= '0;
      landed   <= 1'b0;
    end else if (load) begin
      t_map    <= terrain_in;
      // The start cell can never be a wall, or the lemming would be inside it.
      w_map    <= wall_in & ~START_MASK;
      pos      <= START_P;
      dig_cnt  <= '0;
      fall_cnt <= '0;
      landed   <= 1'b0;
    end else begin
      landed <= 1'b0;

      if (step_l) begin
        pos <= pos_dec;
      end else if (step_r) begin
        pos <= pos_inc;
      end

      // Falling takes priority over digging if both are reported.
      if (aaah) begin
        dig_cnt <= '0;
        if (fall_done) begin
          t_map[pos] <= 1'b1;
          landed     <= 1'b1;
          fall_cnt   <= '0;
        end else begin
          fall_cnt <= fall_cnt + FW'(1);
        end
      end else begin
        fall_cnt <= '0;
        if (digging && ground) begin
          if (dig_done) begin
            t_map[pos] <= 1'b0;
            dig_cnt    <= '0;
          end else begin
            dig_cnt <= dig_cnt + DW'(1);
          end
        end else begin
          dig_cnt <= '0;
        end
      end
    end
  end

`ifdef LEMMING_WORLD_STATS_EN
  logic [15:0] step_cnt_q;
  logic [7:0]  land_cnt_q;

  // Statistics counters, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!resetn || load) begin
      step_cnt_q <= '0;
      land_cnt_q <= '0;
    end else begin
      if ((step_l || step_r) && (step_cnt_q != '1)) begin
        step_cnt_q <= step_cnt_q + 16'd1;
      end
      if (aaah && fall_done && (land_cnt_q != '1)) begin
        land_cnt_q <= land_cnt_q + 8'd1;
      end
    end
  end

  assign step_count = step_cnt_q;
  assign fall_count = land_cnt_q;
`else
  assign step_count = '0;
  assign fall_count = '0;
`endif

endmodule

// File: tb/tb_lemming_world.sv
// -----------------------------------------------------------------------------
// tb_lemming_world
//
// Directed closed-loop bench for lemming_world with default parameters. A
// cell-level behavioural model (integer position, per-cell arrays) tracks
// what the world must look like; one negedge process compares every DUT
// output to it each cycle, and literal expectations pin key points.
// -----------------------------------------------------------------------------
module tb_lemming_world;

  localparam int WIDTH      = 16;
  localparam int START_POS  = 0;
  localparam int DIG_CYCLES = 4;
  localparam int FALL_DEPTH = 3;

`ifdef LEMMING_WORLD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             resetn;
  logic             load;
  logic [WIDTH-1:0] terrain_in;
  logic [WIDTH-1:0] wall_in;
  logic             dig;
  logic             walk_left;
  logic             walk_right;
  logic             aaah;
  logic             digging;
  logic             bump_left;
  logic             bump_right;
  logic             ground;
  logic [3:0]       pos;
  logic             landed;
  logic [15:0]      step_count;
  logic [7:0]       fall_count;

  lemming_world dut (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .terrain_in (terrain_in),
    .wall_in    (wall_in),
    .dig        (dig),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .aaah       (aaah),
    .digging    (digging),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .ground     (ground),
    .pos        (pos),
    .landed     (landed),
    .step_count (step_count),
    .fall_count (fall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_t [WIDTH];
  bit m_w [WIDTH];
  int m_pos    = START_POS;
  int m_dig    = 0;
  int m_fall   = 0;
  bit m_landed = 1'b0;
  int m_steps  = 0;
  int m_falls  = 0;

  function automatic bit m_bl();
    return (m_pos == 0) ? 1'b1 : m_w[m_pos-1];
  endfunction

  function automatic bit m_br();
    return (m_pos == WIDTH-1) ? 1'b1 : m_w[m_pos+1];
  endfunction

  int  mn_pos;
  bit  mg;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < WIDTH; i++) begin
        m_t[i] = 1'b1;
        m_w[i] = 1'b0;
      end
      m_pos = START_POS; m_dig = 0; m_fall = 0; m_landed = 1'b0;
      m_steps = 0; m_falls = 0;
    end else if (load) begin
      for (int i = 0; i < WIDTH; i++) begin
        m_t[i] = terrain_in[i];
        m_w[i] = (i == START_POS) ? 1'b0 : wall_in[i];
      end
      m_pos = START_POS; m_dig = 0; m_fall = 0; m_landed = 1'b0;
      m_steps = 0; m_falls = 0;
    end else begin
      mg       = m_t[m_pos];
      mn_pos   = m_pos;
      m_landed = 1'b0;
      if (walk_left && !walk_right && mg && !m_bl() && !dig) mn_pos = m_pos - 1;
      if (walk_right && !walk_left && mg && !m_br() && !dig) mn_pos = m_pos + 1;
      if (aaah) begin
        m_dig = 0;
        m_fall++;
        if (m_fall == FALL_DEPTH) begin
          m_fall = 0;
          m_t[m_pos] = 1'b1;
          m_landed = 1'b1;
          if (m_falls < 255) m_falls++;
        end
      end else begin
        m_fall = 0;
        if (digging && mg) begin
          m_dig++;
          if (m_dig == DIG_CYCLES) begin
            m_dig = 0;
            m_t[m_pos] = 1'b0;
          end
        end else begin
          m_dig = 0;
        end
      end
      if (mn_pos != m_pos && m_steps < 65535) m_steps++;
      m_pos = mn_pos;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pos",        32'(pos),        m_pos);
      chk("ground",     32'(ground),     32'(m_t[m_pos]));
      chk("bump_left",  32'(bump_left),  32'(m_bl()));
      chk("bump_right", 32'(bump_right), 32'(m_br()));
      chk("landed",     32'(landed),     32'(m_landed));
      chk("step_count", 32'(step_count), STATS ? m_steps : 0);
      chk("fall_count", 32'(fall_count), STATS ? m_falls : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    load = 1'b0; dig = 1'b0; walk_left = 1'b0; walk_right = 1'b0;
    aaah = 1'b0; digging = 1'b0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] w);
    idle();
    terrain_in = t; wall_in = w; load = 1'b1;
    run(1);
    load = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; terrain_in = '0; wall_in = '0;
    idle();
    run(2);
    chk_en = 1'b1;
    chk("rst_pos",    32'(pos), 0);
    chk("rst_bl",     32'(bump_left), 1);
    chk("rst_br",     32'(bump_right), 0);
    chk("rst_ground", 32'(ground), 1);
    chk("rst_landed", 32'(landed), 0);
    chk("model_rst_pos", m_pos, 0);
    resetn = 1'b1;

    // Walk right across the whole track, then stall at the edge.
    walk_right = 1'b1;
    run(20);
    chk("s1_pos15", 32'(pos), 15);
    chk("s1_br",    32'(bump_right), 1);
    chk("model_pos15", m_pos, 15);
    walk_left = 1'b1;                     // both high: illegal, no step
    run(2);
    chk("illegal_hold", 32'(pos), 15);
    walk_right = 1'b0; dig = 1'b1;        // dig blocks stepping
    run(1);
    chk("dig_block", 32'(pos), 15);
    dig = 1'b0;
    run(1);
    chk("step_left", 32'(pos), 14);

    // Wall at cell 4.
    do_load(16'hFFFF, 16'h0010);
    chk("s2_load_pos", 32'(pos), 0);
    walk_right = 1'b1;
    run(8);
    chk("s2_pos3", 32'(pos), 3);
    chk("s2_br",   32'(bump_right), 1);
    chk("s2_bl",   32'(bump_left), 0);
    walk_right = 1'b0; walk_left = 1'b1;
    run(5);
    chk("s2_pos0", 32'(pos), 0);
    chk("s2_bl0",  32'(bump_left), 1);

    // Dig at cell 5: interrupted partial digs must not accumulate.
    do_load(16'hFFFF, 16'h0000);
    walk_right = 1'b1;
    run(5);
    walk_right = 1'b0;
    chk("s3_pos5", 32'(pos), 5);
    digging = 1'b1; run(3);
    digging = 1'b0; run(1);
    digging = 1'b1; run(3);
    digging = 1'b0; run(1);
    chk("s3_partial", 32'(ground), 1);
    digging = 1'b1; run(3);
    chk("s3_dig3", 32'(ground), 1);
    run(1);
    chk("s3_dig4", 32'(ground), 0);
    digging = 1'b0;
    aaah = 1'b1; run(2);
    chk("s3_fall2", 32'(landed), 0);
    run(1);
    chk("s3_landed", 32'(landed), 1);
    chk("s3_ground", 32'(ground), 1);
    aaah = 1'b0; run(1);
    chk("s3_pulse_end", 32'(landed), 0);

    // Pre-existing hole at cell 2.
    do_load(16'hFFFB, 16'h0000);
    walk_right = 1'b1;
    run(3);
    chk("s4_pos2",   32'(pos), 2);
    chk("s4_nognd",  32'(ground), 0);
    walk_right = 1'b0; aaah = 1'b1;
    run(3);
    chk("s4_landed", 32'(landed), 1);
    chk("s4_ground", 32'(ground), 1);
    chk("s4_pos",    32'(pos), 2);
    aaah = 1'b0; run(1);

    // Reset in the middle of a fall.
    do_load(16'hFFFB, 16'h0000);
    walk_right = 1'b1; run(2);
    walk_right = 1'b0; aaah = 1'b1; run(1);
    resetn = 1'b0; run(1);
    chk("s5_pos",    32'(pos), 0);
    chk("s5_ground", 32'(ground), 1);
    chk("s5_landed", 32'(landed), 0);
    chk("s5_fcnt",   32'(fall_count), 0);
    resetn = 1'b1; aaah = 1'b0;
    walk_right = 1'b1; run(20);
    chk("s5_restored", 32'(pos), 15);
    walk_right = 1'b0;

    // Stats: three steps into a hole at cell 3, one landing.
    do_load(16'hFFF7, 16'h0000);
    walk_right = 1'b1; run(4);
    walk_right = 1'b0;
    chk("s6_pos3", 32'(pos), 3);
    aaah = 1'b1; run(3);
    aaah = 1'b0; run(1);
    chk("s6_steps", 32'(step_count), STATS ? 3 : 0);
    chk("s6_falls", 32'(fall_count), STATS ? 1 : 0);

    run(1);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/lemming_world.md
# lemming_world

Synthesizable 1-D terrain model that sits on the other end of the lemming walker FSM interface. It consumes the walker's state outputs (`walk_left`, `walk_right`, `aaah`, `digging`) plus the shared `dig` command. It produces the environment inputs the walker needs: `bump_left`, `bump_right`, `ground`. It tracks lemming position, dug-out cells and fall progress, and is used in closed-loop simulation and on-chip self-test of the walker.

## Interface
- `WIDTH`, 16 — number of cells in the track; must be ≥ 2.
- `START_POS`, 0 — cell the lemming occupies after reset or load; must be < `WIDTH`.
- `DIG_CYCLES`, 4 — consecutive dig cycles needed to remove the ground under a cell; must be ≥ 1.
- `FALL_DEPTH`, 3 — number of cycles a fall lasts before landing; must be ≥ 1.
- `PW` is derived, not a parameter: `PW = $clog2(WIDTH)`.

Ports:
- `clk` in 1 — clock; all state changes on the rising edge.
- `resetn` in 1 — synchronous, active-low reset.
- `load` in 1 — loads the terrain and wall maps from the inputs below.
- `terrain_in` in WIDTH — bit i = 1 means solid ground under cell i.
- `wall_in` in WIDTH — bit i = 1 means cell i is an impassable wall.
- `dig` in 1 — the same dig command that drives the walker.
- `walk_left`, `walk_right`, `aaah`, `digging` in 1 each — the walker's state outputs.
- `bump_left`, `bump_right`, `ground` out 1 each — environment inputs to the walker.
- `pos` out PW — current lemming cell.
- `landed` out 1 — one-cycle pulse on the cycle the fall ends.
- `step_count` out 16 — stats output; see Configuration.
- `fall_count` out 8 — stats output; see Configuration.

## Operation
- State registers:
  - `T[WIDTH-1:0]` terrain map.
  - `W[WIDTH-1:0]` wall map.
  - `pos`.
  - `dig_cnt`, range 0..DIG_CYCLES-1.
  - `fall_cnt`, range 0..FALL_DEPTH-1.
- Reset (`resetn`=0) values:
  - T = all ones, W = all zeros, pos = START_POS.
  - dig_cnt = 0, fall_cnt = 0.
  - landed = 0, step_count = 0, fall_count = 0.
- Load (`load`=1, `resetn`=1):
  - T ← terrain_in, W ← wall_in, with `W[START_POS]` forced to 0.
  - pos ← START_POS; all counters and stats cleared.
  - Load overrides every rule below for that cycle.
- Combinational outputs from registered state:
  - `ground = T[pos]`.
  - `bump_left = (pos==0) | W[pos-1]`.
  - `bump_right = (pos==WIDTH-1) | W[pos+1]`.
  - Both bump outputs are independent of walker state. Out-of-range indices are never evaluated; the edge term covers them.
- Step: `pos` changes only on these conditions. If `walk_right` and `walk_left` are both 1 (illegal), there is no step.
  - pos ← pos-1 when `walk_left & ~walk_right & ground & ~bump_left & ~dig`.
  - pos ← pos+1 when `walk_right & ~walk_left & ground & ~bump_right & ~dig`.
- Dig, when `digging & ground`:
  - If dig_cnt == DIG_CYCLES-1: T[pos] ← 0 and dig_cnt ← 0.
  - Otherwise dig_cnt increments.
  - When `digging` is 0, dig_cnt ← 0, so partial digs do not accumulate.
- Fall, when `aaah`:
  - If fall_cnt == FALL_DEPTH-1: T[pos] ← 1 (lemming lands on the pit floor), landed ← 1, fall_cnt ← 0.
  - Otherwise fall_cnt increments.
  - When `aaah` is 0, fall_cnt ← 0.
  - `landed` is 0 on every other cycle.
- Mutually exclusive walker outputs are assumed legal. If `digging` and `aaah` are both 1, fall rules win and dig_cnt clears.

## Timing
- All registers update on the `clk` rising edge. `ground`/bump outputs reflect the new `pos`/T in the same cycle the register updates (zero-latency combinational decode).
- Hole creation: the edge that clears T[pos] makes `ground`=0 immediately after it. The walker sees it and enters its falling state on the next edge.
- A fall lasts exactly FALL_DEPTH cycles with `aaah`=1. `ground` rises after the FALL_DEPTH-th edge.
- Reset mid-fall or mid-dig discards the partial count. Restored terrain reverts to all ones.

## Configuration
- `LEMMING_WORLD_STATS_EN` defined:
  - `step_count` increments on every step.
  - `fall_count` increments on every `landed` pulse.
  - Both saturate at all-ones and clear on reset or load.
- Not defined: `step_count` and `fall_count` are tied to 0 and no counter flops are built.

## Test plan
- Reset, then walker drives `walk_right`=1 for 20 cycles with default params → `pos` goes 0→15. `bump_right`=1 at pos 15, `pos` holds at 15.
- Load `wall_in`=16'h0010, `START_POS`=0, `walk_right` held → `pos` stops at 3 with `bump_right`=1. `bump_left`=1 only at pos 0.
- `digging`=1 at pos 5 for 4 cycles → T[5] clears after 4th edge, `ground`=0. Dig 3 cycles, drop 1, dig 3 → T[5] unchanged.
- Load `terrain_in`=16'hFFFB, walk right from 0 → `ground`=0 at pos 2. `aaah` for 3 cycles → `landed` pulse, `ground`=1, `pos`=2, T[2]=1.
- `resetn`=0 mid-fall (fall_cnt=1) → next cycle: pos=0, T=all ones, `landed`=0. With STATS macro, `fall_count`=0.
- With `LEMMING_WORLD_STATS_EN`, 3 steps plus 1 landing → `step_count`=3, `fall_count`=1. Without the macro → both 0.
